// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit, one SEG-bit segment resolved per stage.
// The inter-segment carry is registered between stages, so the critical path is
// a single SEG-bit adder regardless of WIDTH. The operands ride along in skew
// registers and finished low result segments travel forward with them. A single
// global advance enable (adv) moves every stage at once.
//
// stage | meaning
// ------+-------------------------------------------------------------
// k     | result bits [(k+1)*SEG-1:0] resolved; carry out of segment k
// LAST  | output registers: s, cout, zero; overflow from its sign bits

module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  generate
    if ((SEG < 2) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_param_check
      $error("adder_pipe: WIDTH must be a multiple of SEG and 2 <= SEG <= WIDTH");
    end
  endgenerate

  // Stage registers. a_q/b_q hold the (effective) operands so later stages can
  // pick up their segment; s_q accumulates the finished low segments.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic             z_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  // Inputs seen by each stage: the port side for stage 0, the previous stage
  // registers otherwise.
  logic             in_v [STAGES];
  logic             in_c [STAGES];
  logic             in_z [STAGES];
  logic [WIDTH-1:0] in_a [STAGES];
  logic [WIDTH-1:0] in_b [STAGES];
  logic [WIDTH-1:0] in_s [STAGES];

  // Per-stage next values.
  logic [SEG:0]     seg_sum [STAGES];
  logic [WIDTH-1:0] nx_s    [STAGES];
  logic             nx_c    [STAGES];
  logic             nx_z    [STAGES];

  logic adv;

  assign adv       = !v_q[LAST] || out_ready;
  assign in_ready  = adv && reset_n;

  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign zero      = z_q[LAST];
  // Equivalent to carry-into-MSB xor carry-out; uses the effective operand B'.
  // Registers are all zero after reset or for a bubble, which yields 0 here.
  assign overflow  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

  // Route each stage's inputs: stage 0 from the ports, the rest from the previous stage.
  always_comb begin
    in_v[0] = in_valid;
    in_a[0] = a;
    in_b[0] = sub ? ~b : b;
    in_c[0] = cin ^ sub;
    in_z[0] = 1'b1;
    in_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = v_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_c[k] = c_q[k-1];
      in_z[k] = z_q[k-1];
      in_s[k] = s_q[k-1];
    end
  end

  // Resolve one SEG-bit segment per stage and fold its zero test into the running flag.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, in_a[k][k*SEG +: SEG]}
                 + {1'b0, in_b[k][k*SEG +: SEG]}
                 + (SEG+1)'(in_c[k]);
      nx_s[k] = in_s[k];
      nx_s[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      nx_c[k] = seg_sum[k][SEG];
      nx_z[k] = in_z[k] && (seg_sum[k][SEG-1:0] == '0);
    end
  end

  // Advance the whole pipe on adv; bubbles load zeros so idle stages carry clean flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        z_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= in_v[k];
        if (in_v[k]) begin
          c_q[k] <= nx_c[k];
          z_q[k] <= nx_z[k];
          a_q[k] <= in_a[k];
          b_q[k] <= in_b[k];
          s_q[k] <= nx_s[k];
        end else begin
          c_q[k] <= 1'b0;
          z_q[k] <= 1'b0;
          a_q[k] <= '0;
          b_q[k] <= '0;
          s_q[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: three instances (32/8, 16/4, 8/8) checked every cycle
// against a transaction-slot model whose results come from signed/unsigned
// integer arithmetic, plus directed cases with literal expectations.

module tb_adder_pipe;

  typedef struct packed {
    logic        v;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic clock;
  logic reset_n;

  logic        vin  [3];
  logic        ord  [3];
  logic [31:0] opa  [3];
  logic [31:0] opb  [3];
  logic        ocin [3];
  logic        osub [3];

  logic        dv  [3];
  logic        dr  [3];
  logic [31:0] ds  [3];
  logic        dc  [3];
  logic        dov [3];
  logic        dz  [3];

  logic        ov_0, ov_1, ov_2, ir_0, ir_1, ir_2;
  logic        c_0, c_1, c_2, o_0, o_1, o_2, z_0, z_1, z_2;
  logic [31:0] s_0;
  logic [15:0] s_1;
  logic [7:0]  s_2;

  res_t mdl [3][4];

  int checks   = 0;
  int failures = 0;
  int outs0    = 0;

  adder_pipe #(.WIDTH(32), .SEG(8)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .in_valid(vin[0]), .in_ready(ir_0),
    .a(opa[0]), .b(opb[0]), .cin(ocin[0]), .sub(osub[0]),
    .out_valid(ov_0), .out_ready(ord[0]), .s(s_0), .cout(c_0), .overflow(o_0), .zero(z_0));

  adder_pipe #(.WIDTH(16), .SEG(4)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(vin[1]), .in_ready(ir_1),
    .a(opa[1][15:0]), .b(opb[1][15:0]), .cin(ocin[1]), .sub(osub[1]),
    .out_valid(ov_1), .out_ready(ord[1]), .s(s_1), .cout(c_1), .overflow(o_1), .zero(z_1));

  adder_pipe #(.WIDTH(8), .SEG(8)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(vin[2]), .in_ready(ir_2),
    .a(opa[2][7:0]), .b(opb[2][7:0]), .cin(ocin[2]), .sub(osub[2]),
    .out_valid(ov_2), .out_ready(ord[2]), .s(s_2), .cout(c_2), .overflow(o_2), .zero(z_2));

  always_comb begin
    dv[0] = ov_0; dv[1] = ov_1; dv[2] = ov_2;
    dr[0] = ir_0; dr[1] = ir_1; dr[2] = ir_2;
    ds[0] = s_0;  ds[1] = {16'h0, s_1}; ds[2] = {24'h0, s_2};
    dc[0] = c_0;  dc[1] = c_1;  dc[2] = c_2;
    dov[0] = o_0; dov[1] = o_1; dov[2] = o_2;
    dz[0] = z_0;  dz[1] = z_1;  dz[2] = z_2;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int wid(int i);
    return (i == 0) ? 32 : (i == 1) ? 16 : 8;
  endfunction

  function automatic int stg(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  // Reference result from integer arithmetic: a+b+cin or a-b-cin.
  function automatic res_t calc(int w, logic [31:0] x, logic [31:0] y, logic ci, logic sb);
    res_t t;
    longint m, ux, uy, sx, sy, r, c;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    c  = longint'(ci);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    t = '0;
    t.v = 1'b1;
    if (!sb) begin
      t.c = (ux + uy + c >= m);
      r   = sx + sy + c;
    end else begin
      t.c = (ux >= uy + c);
      r   = sx - sy - c;
    end
    t.o = (r >= m / 2) || (r < -(m / 2));
    t.s = 32'(((r % m) + m) % m);
    t.z = (t.s == 32'h0);
    return t;
  endfunction

  // Transaction slots: shift on advance, a new slot enters per edge (empty for a bubble).
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 4; k++) mdl[i][k] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!mdl[i][stg(i)-1].v || ord[i]) begin
          for (int k = 3; k > 0; k--) mdl[i][k] <= mdl[i][k-1];
          if (vin[i]) mdl[i][0] <= calc(wid(i), opa[i], opb[i], ocin[i], osub[i]);
          else        mdl[i][0] <= '0;
        end
      end
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    res_t last;
    logic exp_rdy;
    for (int i = 0; i < 3; i++) begin
      last = mdl[i][stg(i)-1];
      exp_rdy = reset_n && (!last.v || ord[i]);
      chk(dv[i] == last.v, $sformatf("out_valid[%0d]", i), 32'(dv[i]), 32'(last.v));
      chk(dr[i] == exp_rdy, $sformatf("in_ready[%0d]", i), 32'(dr[i]), 32'(exp_rdy));
      if (last.v && dv[i]) begin
        chk(ds[i] == last.s, $sformatf("s[%0d]", i), ds[i], last.s);
        chk(dc[i] == last.c, $sformatf("cout[%0d]", i), 32'(dc[i]), 32'(last.c));
        chk(dov[i] == last.o, $sformatf("overflow[%0d]", i), 32'(dov[i]), 32'(last.o));
        chk(dz[i] == last.z, $sformatf("zero[%0d]", i), 32'(dz[i]), 32'(last.z));
      end
      if (!reset_n)
        chk({ds[i], dc[i], dov[i], dz[i]} == '0, $sformatf("reset_flags[%0d]", i),
            {ds[i][28:0], dc[i], dov[i], dz[i]}, 32'h0);
    end
  endtask

  logic        prev_hold = 1'b0;
  logic [34:0] prev_out  = '0;

  task automatic do_one(input logic [31:0] xa, input logic [31:0] xb, input logic ci, input logic sb,
                        input logic [31:0] es, input logic ec, input logic eo, input logic ez,
                        input string nm);
    int n;
    @(posedge clock); #2;
    opa[0] = xa; opb[0] = xb; ocin[0] = ci; osub[0] = sb; vin[0] = 1'b1; ord[0] = 1'b1;
    @(posedge clock); #1;
    vin[0] = 1'b0;
    n = 1;
    while (!dv[0] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk(n == 4, {nm, "_latency"}, 32'(n), 32'd4);
    chk(ds[0] == es, {nm, "_s"}, ds[0], es);
    chk(dc[0] == ec, {nm, "_cout"}, 32'(dc[0]), 32'(ec));
    chk(dov[0] == eo, {nm, "_overflow"}, 32'(dov[0]), 32'(eo));
    chk(dz[0] == ez, {nm, "_zero"}, 32'(dz[0]), 32'(ez));
    @(posedge clock); #1;
  endtask

  initial begin
    res_t p;
    int   sent, base, rdy;
    bit   newtxn;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; ord[i] = 1'b1; opa[i] = '0; opb[i] = '0; ocin[i] = 1'b0; osub[i] = 1'b0;
    end

    fork
      forever begin
        @(negedge clock);
        compare_all();
        if (reset_n && prev_hold)
          chk({ds[0], dc[0], dov[0], dz[0]} == prev_out, "hold_outputs", ds[0], prev_out[34:3]);
        prev_hold = reset_n && dv[0] && !ord[0];
        prev_out  = {ds[0], dc[0], dov[0], dz[0]};
        if (reset_n && dv[0] && ord[0]) outs0++;
      end
    join_none

    #1;
    chk(dv[0] == 1'b0, "reset_out_valid", 32'(dv[0]), 32'h0);
    chk(dr[0] == 1'b0, "reset_in_ready", 32'(dr[0]), 32'h0);
    chk(ds[0] == 32'h0, "reset_s", ds[0], 32'h0);

    // Pin the reference model to hand-computed values.
    p = calc(32, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    chk(p.s == 32'h80000000 && p.o && !p.c && !p.z, "model_add_ovf", p.s, 32'h80000000);
    p = calc(32, 32'h80000000, 32'h1, 1'b0, 1'b1);
    chk(p.s == 32'h7FFFFFFF && p.o && p.c, "model_sub_ovf", p.s, 32'h7FFFFFFF);
    p = calc(16, 32'h7FFF, 32'h1, 1'b0, 1'b0);
    chk(p.s == 32'h8000 && p.o && !p.c, "model16_add_ovf", p.s, 32'h8000);
    p = calc(8, 32'h0, 32'h1, 1'b0, 1'b1);
    chk(p.s == 32'hFF && !p.c && !p.o, "model8_sub", p.s, 32'hFF);

    #11 reset_n = 1'b1;

    do_one(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, "add_ovf");
    do_one(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, "ripple");
    do_one(32'd5,        32'd5, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, "sub_5_5");
    do_one(32'h0,        32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "sub_0_1");
    do_one(32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "sub_min_1");
    do_one(32'd10,       32'd3, 1'b1, 1'b1, 32'd6,        1'b1, 1'b0, 1'b0, "sub_10_3_b");

    // Back-pressure: 8 back-to-back transactions, out_ready low for 3 cycles mid-stream.
    base = outs0;
    sent = 0;
    newtxn = 1'b1;
    @(posedge clock);
    for (int cyc = 0; cyc < 40 && sent < 8; cyc++) begin
      #2;
      if (newtxn) begin
        opa[0] = $urandom; opb[0] = $urandom;
        ocin[0] = 1'($urandom_range(0, 1)); osub[0] = 1'($urandom_range(0, 1));
      end
      vin[0] = 1'b1;
      ord[0] = !(cyc >= 3 && cyc < 6);
      #1;
      rdy = int'(dr[0]);
      if (!ord[0] && dv[0]) chk(dr[0] == 1'b0, "bp_in_ready_low", 32'(dr[0]), 32'h0);
      @(posedge clock);
      newtxn = (rdy != 0);
      if (rdy != 0) sent++;
    end
    #2;
    vin[0] = 1'b0; ord[0] = 1'b1;
    chk(sent == 8, "bp_accepted", 32'(sent), 32'd8);
    repeat (10) @(posedge clock);
    #2;
    chk(outs0 - base == 8, "bp_delivered", 32'(outs0 - base), 32'd8);

    // Reset with three transactions in flight.
    @(posedge clock); #2;
    for (int t = 0; t < 3; t++) begin
      opa[0] = $urandom; opb[0] = $urandom; ocin[0] = 1'b0; osub[0] = 1'b0; vin[0] = 1'b1;
      @(posedge clock); #2;
    end
    vin[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk(dv[0] == 1'b0, "rst_mid_out_valid", 32'(dv[0]), 32'h0);
    chk(dr[0] == 1'b0, "rst_mid_in_ready", 32'(dr[0]), 32'h0);
    chk({ds[0], dc[0], dov[0], dz[0]} == '0, "rst_mid_flags", ds[0], 32'h0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    do_one(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0, "post_reset");

    // Random traffic on all three widths with random bubbles and stalls.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clock); #2;
      for (int i = 0; i < 3; i++) begin
        vin[i]  = ($urandom_range(0, 3) != 0);
        ord[i]  = ($urandom_range(0, 3) != 0);
        opa[i]  = $urandom;
        opb[i]  = $urandom;
        ocin[i] = 1'($urandom_range(0, 1));
        osub[i] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: opa[i] = '1;
          1: opb[i] = '0;
          2: opb[i] = opa[i];
          default: ;
        endcase
      end
    end
    @(posedge clock); #2;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; ord[i] = 1'b1;
    end
    repeat (8) @(posedge clock);
    @(negedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
